// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared types and widths for the QPSK demapper scheduler
package qpsk_pkg;
    localparam int SYM_W = 2;
    localparam int ENTRY_W = 2 * SYM_W;
    typedef enum logic [1:0] {IDLE, SEND_I, SEND_Q} state_t;
endpackage

// File: rtl/qpsk_demap_sched_if.sv
// qpsk_demap_sched_if: decided-symbol input and serialized bit-stream output
interface qpsk_demap_sched_if;
    logic [qpsk_pkg::SYM_W-1:0] sym_i;
    logic [qpsk_pkg::SYM_W-1:0] sym_q;
    logic                       sym_valid;
    logic [qpsk_pkg::SYM_W-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_sof;
    logic                       out_eof;
    modport master (
        output sym_i, sym_q, sym_valid, out_ready,
        input  out_data, out_valid, out_sof, out_eof
    );
    modport slave (
        input  sym_i, sym_q, sym_valid, out_ready,
        output out_data, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/qpsk_sym_fifo.sv
// qpsk_sym_fifo: synchronous symbol FIFO with first-word head output
module qpsk_sym_fifo import qpsk_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_fs,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [ENTRY_W-1:0]          din,
    output logic [ENTRY_W-1:0]          dout,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = level == (AW + 1)'(FIFO_DEPTH);
    assign empty = level == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/qpsk_demap_sched.sv
// qpsk_demap_sched: buffers I/Q decisions and serializes them I-then-Q with frame marks
module qpsk_demap_sched import qpsk_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN = 64
) (
    input  logic                        clk_fs,
    input  logic                        rst,
    input  logic                        en,
    qpsk_demap_sched_if.slave           bus,
    output logic                        ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    state_t state;
    logic [SYM_W-1:0] hold_i, hold_q;
    logic [CW-1:0] sym_cnt, cnt_nxt;
    logic [ENTRY_W-1:0] head;
    logic full, empty, pop, push;
    assign cnt_nxt = (sym_cnt == LAST) ? '0 : sym_cnt + 1'b1;
    assign pop = en && !empty && (state == IDLE || (state == SEND_Q && bus.out_ready));
    assign push = bus.sym_valid && (!full || pop);
    assign bus.out_data = (state == SEND_Q) ? hold_q : hold_i;
    qpsk_sym_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_fs (clk_fs),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    ({bus.sym_i, bus.sym_q}),
        .dout   (head),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );
    // en only gates pops, so a started symbol always finishes its Q word
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state <= IDLE;
            hold_i <= '0;
            hold_q <= '0;
            sym_cnt <= '0;
            ovf <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sof <= 1'b0;
            bus.out_eof <= 1'b0;
        end else begin
            if (bus.sym_valid && !push) ovf <= 1'b1;
            if (pop) {hold_i, hold_q} <= head;
            case (state)
                IDLE: if (pop) begin
                    state <= SEND_I;
                    bus.out_valid <= 1'b1;
                    bus.out_sof <= sym_cnt == '0;
                    bus.out_eof <= 1'b0;
                end
                SEND_I: if (bus.out_ready) begin
                    state <= SEND_Q;
                    bus.out_sof <= 1'b0;
                    bus.out_eof <= sym_cnt == LAST;
                end
                SEND_Q: if (bus.out_ready) begin
                    sym_cnt <= cnt_nxt;
                    state <= pop ? SEND_I : IDLE;
                    bus.out_valid <= pop;
                    bus.out_sof <= pop && cnt_nxt == '0;
                    bus.out_eof <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qpsk_demap_sched.sv
// tb_qpsk_demap_sched: directed stimulus checked against a queue-level word-stream model
module tb_qpsk_demap_sched;
    localparam int FL = 4;
    localparam int DEPTH = 4;
    typedef struct {logic [1:0] d; logic sof; logic eof;} word_t;

    logic clk_fs = 1'b0;
    logic rst, en, ovf;
    logic [2:0] fifo_level;
    qpsk_demap_sched_if bus();

    qpsk_demap_sched #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .clk_fs     (clk_fs),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .ovf        (ovf),
        .fifo_level (fifo_level)
    );

    always #5 clk_fs = ~clk_fs;

    int n_chk = 0, n_pass = 0;
    int n_sof, n_eof;
    bit run = 0, cnt_on = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // model: FIFO contents plus the queue of words still to be delivered
    logic [3:0] fq[$];
    word_t words[$];
    int nsym;
    bit m_ovf;
    logic [3:0] m_s;

    always @(posedge clk_fs) begin
        if (rst) begin
            fq.delete();
            words.delete();
            nsym = 0;
            m_ovf = 0;
        end else begin
            if (words.size() != 0 && bus.out_ready) void'(words.pop_front());
            if (en && words.size() == 0 && fq.size() != 0) begin
                m_s = fq.pop_front();
                words.push_back(word_t'{m_s[3:2], (nsym % FL) == 0, 1'b0});
                words.push_back(word_t'{m_s[1:0], 1'b0, (nsym % FL) == FL - 1});
                nsym++;
            end
            if (bus.sym_valid) begin
                if (fq.size() < DEPTH) fq.push_back({bus.sym_i, bus.sym_q});
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk_fs) begin
        if (run) begin
            chk("m_valid", bus.out_valid, words.size() != 0);
            if (words.size() != 0) begin
                chk("m_data", bus.out_data, words[0].d);
                chk("m_sof", bus.out_sof, words[0].sof);
                chk("m_eof", bus.out_eof, words[0].eof);
            end
            chk("m_level", fifo_level, fq.size());
            chk("m_ovf", ovf, m_ovf);
        end
        if (cnt_on && bus.out_valid && bus.out_ready) begin
            n_sof += bus.out_sof;
            n_eof += bus.out_eof;
        end
    end

    task automatic step(input logic v, input logic [1:0] si, input logic [1:0] sq);
        @(negedge clk_fs);
        bus.sym_valid = v;
        bus.sym_i = si;
        bus.sym_q = sq;
    endtask

    task automatic do_reset();
        @(negedge clk_fs);
        rst = 1'b1;
        @(negedge clk_fs);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        bus.out_ready = 1'b1;
        bus.sym_valid = 1'b0;
        bus.sym_i = '0;
        bus.sym_q = '0;
        repeat (2) @(posedge clk_fs);
        @(negedge clk_fs);
        rst = 1'b0;
        run = 1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf, 0);

        // single symbol: I=10, Q=01
        step(1, 2'b10, 2'b01);
        step(0, 2'b00, 2'b00);
        chk("single_idle", bus.out_valid, 0);
        chk("single_lvl1", fifo_level, 1);
        @(negedge clk_fs);
        chk("single_i", bus.out_data, 2);
        chk("single_sof", bus.out_sof, 1);
        @(negedge clk_fs);
        chk("single_q", bus.out_data, 1);
        chk("single_eof", bus.out_eof, 0);
        @(negedge clk_fs);
        chk("single_done", bus.out_valid, 0);
        chk("single_lvl0", fifo_level, 0);

        // back-pressure in the middle of a Q word
        step(1, 2'b11, 2'b00);
        step(1, 2'b01, 2'b10);
        step(0, 2'b00, 2'b00);
        chk("bp_i0", bus.out_data, 3);
        @(negedge clk_fs);
        chk("bp_q0", bus.out_data, 0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_fs);
            chk("bp_hold_data", bus.out_data, 0);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk_fs);
        chk("bp_i1", bus.out_data, 1);
        @(negedge clk_fs);
        chk("bp_q1", bus.out_data, 2);
        repeat (2) @(negedge clk_fs);

        // enable drop during SEND_I; symbol 3 of the frame completes, rest wait
        step(1, 2'b10, 2'b11);
        step(1, 2'b00, 2'b01);
        step(1, 2'b11, 2'b10);
        en = 1'b0;
        chk("en_i", bus.out_data, 2);
        step(0, 2'b00, 2'b00);
        chk("en_q", bus.out_data, 3);
        chk("en_q_eof", bus.out_eof, 1);
        @(negedge clk_fs);
        chk("en_idle", bus.out_valid, 0);
        chk("en_lvl", fifo_level, 2);
        repeat (3) begin
            @(negedge clk_fs);
            chk("en_stay_idle", bus.out_valid, 0);
        end
        en = 1'b1;
        @(negedge clk_fs);
        chk("en_resume_sof", bus.out_sof, 1);
        chk("en_resume_i", bus.out_data, 0);
        repeat (6) @(negedge clk_fs);

        // frame marks over 9 symbols
        do_reset();
        n_sof = 0;
        n_eof = 0;
        cnt_on = 1;
        for (int k = 0; k < 9; k++) begin
            step(1, 2'(k), 2'(k + 1));
            step(0, 2'b00, 2'b00);
        end
        repeat (6) @(negedge clk_fs);
        cnt_on = 0;
        chk("frame_sof_cnt", n_sof, 3);
        chk("frame_eof_cnt", n_eof, 2);

        // overflow with the sink stalled
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) step(1, 2'(k), 2'(3 - k));
        step(0, 2'b00, 2'b00);
        chk("ovf_lvl", fifo_level, 4);
        chk("ovf_set", ovf, 1);
        bus.out_ready = 1'b1;
        repeat (12) @(negedge clk_fs);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_drained", fifo_level, 0);

        // reset while sending Q with three symbols queued
        for (int k = 0; k < 5; k++) step(1, 2'(k + 1), 2'(k));
        step(0, 2'b00, 2'b00);
        chk("mid_lvl3", fifo_level, 3);
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_ovf", ovf, 1);
        rst = 1'b1;
        @(negedge clk_fs);
        rst = 1'b0;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_sof", bus.out_sof, 0);
        chk("mid_rst_eof", bus.out_eof, 0);
        chk("mid_rst_lvl", fifo_level, 0);
        chk("mid_rst_ovf", ovf, 0);
        step(1, 2'b01, 2'b11);
        step(0, 2'b00, 2'b00);
        @(negedge clk_fs);
        chk("post_rst_sof", bus.out_sof, 1);
        chk("post_rst_i", bus.out_data, 1);
        repeat (3) @(negedge clk_fs);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
